// File: rtl/alu_control_sequencer_pkg.sv
// Shared encodings for the ALU control sequencer: states, opcodes,
// function selects, flag bit positions and opcode classification.
package alu_control_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_WB      = 3'd3;
    localparam logic [2:0] S_FLAGCHK = 3'd4;

    localparam logic [5:0] OP_CMP = 6'h10;
    localparam logic [5:0] OP_BEQ = 6'h11;
    localparam logic [5:0] OP_BNE = 6'h12;
    localparam logic [5:0] OP_BCS = 6'h13;
    localparam logic [5:0] OP_BCC = 6'h14;
    localparam logic [5:0] OP_BMI = 6'h15;
    localparam logic [5:0] OP_BVS = 6'h16;

    localparam logic [3:0] FUN_SUB  = 4'b0110;
    localparam logic [4:0] FUN_NONE = 5'b00000;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        K_ALU,
        K_CMP,
        K_BRANCH,
        K_ILLEGAL
    } op_kind_e;

    function automatic op_kind_e classify(input logic [5:0] op);
        op_kind_e k;
        if (op[5:4] == 2'b00)
            k = K_ALU;
        else if (op == OP_CMP)
            k = K_CMP;
        else if (op >= OP_BEQ && op <= OP_BVS)
            k = K_BRANCH;
        else
            k = K_ILLEGAL;
        return k;
    endfunction

endpackage

// File: rtl/alu_control_sequencer_branch.sv
// Branch condition evaluator: low opcode bits select a flag test.
module branch_cond_eval
    import alu_control_sequencer_pkg::*;
(
    input  logic [2:0] code_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        unique case (1'b1)
            code_i == OP_BEQ[2:0]: taken_o = flags_i[FLAG_Z];
            code_i == OP_BNE[2:0]: taken_o = !flags_i[FLAG_Z];
            code_i == OP_BCS[2:0]: taken_o = flags_i[FLAG_C];
            code_i == OP_BCC[2:0]: taken_o = !flags_i[FLAG_C];
            code_i == OP_BMI[2:0]: taken_o = flags_i[FLAG_N];
            code_i == OP_BVS[2:0]: taken_o = flags_i[FLAG_O];
            default:               taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Multi-cycle control FSM driving ALU function select, flag write,
// register load and branch resolution for one instruction at a time.
module alu_control_sequencer
    import alu_control_sequencer_pkg::*;
#(
    parameter bit FLAGS_ON_MOVE = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [5:0] Opcode,
    input  logic       Wide,
    input  logic [3:0] FlagsIn,
    output logic [4:0] FunSel,
    output logic       WF,
    output logic       RegLoad,
    output logic       Busy,
    output logic       Done,
    output logic       BranchTaken,
    output logic       Illegal
);

    logic [2:0] state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       wide_q, wide_d;
    logic       cond_taken;
    op_kind_e   kind;

    assign kind = classify(op_q);

    branch_cond_eval u_cond (
        .code_i  (op_q[2:0]),
        .flags_i (FlagsIn),
        .taken_o (cond_taken)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wide_d  = wide_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_DECODE;
                    op_d    = Opcode;
                    wide_d  = Wide;
                end
            end
            S_DECODE: begin
                unique case (kind)
                    K_ALU, K_CMP: state_d = S_EXEC;
                    K_BRANCH:     state_d = S_FLAGCHK;
                    default:      state_d = S_IDLE;
                endcase
            end
            S_EXEC:    state_d = S_WB;
            S_WB:      state_d = S_IDLE;
            S_FLAGCHK: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= 6'd0;
            wide_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wide_q  <= wide_d;
        end
    end

    logic in_dec, in_exec, in_wb, in_chk, act, move_op;

    assign in_dec  = state_q == S_DECODE;
    assign in_exec = state_q == S_EXEC;
    assign in_wb   = state_q == S_WB;
    assign in_chk  = state_q == S_FLAGCHK;
    assign act     = !Reset;
    assign move_op = op_q[3:2] == 2'b00;

    // Outputs are gated by Reset so an aborted op shows nothing in the reset cycle.
    always_comb begin
        FunSel = FUN_NONE;
        if (act && (in_exec || in_wb))
            FunSel = (kind == K_CMP) ? {wide_q, FUN_SUB} : {wide_q, op_q[3:0]};
    end

    assign WF = act && in_exec &&
                (kind == K_CMP || FLAGS_ON_MOVE || !move_op);
    assign RegLoad     = act && in_wb && kind == K_ALU;
    assign Busy        = act && state_q != S_IDLE;
    assign Illegal     = act && in_dec && kind == K_ILLEGAL;
    assign Done        = act && (in_wb || in_chk || (in_dec && kind == K_ILLEGAL));
    assign BranchTaken = act && in_chk && cond_taken;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized scoreboard bench for the ALU control sequencer.
module tb_alu_control_sequencer;

    localparam bit FOM = 1'b1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       Wide = 1'b0;
    logic [3:0] FlagsIn = 4'd0;
    logic [4:0] FunSel;
    logic       WF, RegLoad, Busy, Done, BranchTaken, Illegal;

    alu_control_sequencer #(.FLAGS_ON_MOVE(FOM)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Opcode      (Opcode),
        .Wide        (Wide),
        .FlagsIn     (FlagsIn),
        .FunSel      (FunSel),
        .WF          (WF),
        .RegLoad     (RegLoad),
        .Busy        (Busy),
        .Done        (Done),
        .BranchTaken (BranchTaken),
        .Illegal     (Illegal)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int         start;
        int         lat;
        int         wf;
        int         rl;
        bit         taken;
        bit         ill;
        logic [4:0] fs;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: what each instruction class should produce, from the ISA table.
    function automatic exp_t model(input logic [5:0] op, input logic w,
                                   input logic [3:0] f, input int st);
        exp_t e;
        e.start = st; e.wf = 0; e.rl = 0; e.taken = 0; e.ill = 0; e.fs = 5'd0;
        if (op < 6'h10) begin
            e.lat = 3; e.rl = 1;
            e.wf  = (op >= 6'h04 || FOM) ? 1 : 0;
            e.fs  = {w, op[3:0]};
        end else if (op == 6'h10) begin
            e.lat = 3; e.wf = 1; e.fs = {w, 4'b0110};
        end else if (op >= 6'h11 && op <= 6'h16) begin
            e.lat = 2;
            case (op)
                6'h11:   e.taken = f[3];
                6'h12:   e.taken = !f[3];
                6'h13:   e.taken = f[2];
                6'h14:   e.taken = !f[2];
                6'h15:   e.taken = f[1];
                default: e.taken = f[0];
            endcase
        end else begin
            e.lat = 1; e.ill = 1;
        end
        return e;
    endfunction

    int         wf_acc = 0;
    int         rl_acc = 0;
    logic [4:0] fs2 = 5'd0, fs3 = 5'd0;

    always @(negedge Clock) begin
        if (Reset) begin
            wf_acc = 0; rl_acc = 0;
            chk("reset_outputs",
                int'({FunSel, WF, RegLoad, Busy, Done, BranchTaken, Illegal}), 0);
        end else begin
            if (!Busy)
                chk("idle_outputs",
                    int'({FunSel, WF, RegLoad, Done, BranchTaken, Illegal}), 0);
            wf_acc += int'(WF);
            rl_acc += int'(RegLoad);
            if (q.size() > 0) begin
                if (cyc - q[0].start == 2) fs2 = FunSel;
                if (cyc - q[0].start == 3) fs3 = FunSel;
            end
            if (Done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_latency", cyc - e.start, e.lat);
                    chk("wf_count", wf_acc, e.wf);
                    chk("regload_count", rl_acc, e.rl);
                    chk("branch_taken", int'(BranchTaken), int'(e.taken));
                    chk("illegal", int'(Illegal), int'(e.ill));
                    if (e.lat >= 2) chk("funsel_c2", int'(fs2), e.lat == 3 ? int'(e.fs) : 0);
                    if (e.lat == 3) chk("funsel_c3", int'(fs3), int'(e.fs));
                end
                wf_acc = 0; rl_acc = 0;
            end else begin
                chk("pulse_without_done", int'({BranchTaken, Illegal}), 0);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 20) begin
            step();
            n++;
        end
        if (Busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [5:0] op, input logic w, input logic [3:0] f);
        wait_idle();
        q.push_back(model(op, w, f, cyc));
        Start = 1'b1; Opcode = op; Wide = w; FlagsIn = 4'($urandom);
        step();
        Start = 1'b0; Opcode = 6'($urandom); Wide = 1'($urandom);
        FlagsIn = 4'($urandom);
        step();
        FlagsIn = f;
        step();
        FlagsIn = 4'($urandom);
    endtask

    task automatic held_start(input logic [5:0] op, input logic w);
        wait_idle();
        q.push_back(model(op, w, 4'd0, cyc));
        q.push_back(model(op, w, 4'd0, cyc + 4));
        Start = 1'b1; Opcode = op; Wide = w;
        repeat (5) step();
        Start = 1'b0;
    endtask

    task automatic reset_abort(input logic [5:0] op, input logic [3:0] f);
        wait_idle();
        Start = 1'b1; Opcode = op; Wide = 1'b1; FlagsIn = f;
        step();
        Start = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
    endtask

    initial begin
        repeat (3) step();
        Reset = 1'b0;
        step();

        issue(6'h04, 1'b1, 4'd0);
        issue(6'h10, 1'b0, 4'd0);
        issue(6'h11, 1'b0, 4'b1000);
        issue(6'h14, 1'b1, 4'b0100);
        issue(6'h3F, 1'b0, 4'd0);
        issue(6'h00, 1'b0, 4'd0);
        held_start(6'h07, 1'b1);
        reset_abort(6'h04, 4'd0);
        reset_abort(6'h14, 4'd0);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 3))
                0:       op = 6'($urandom_range(0, 15));
                1:       op = 6'h10;
                2:       op = 6'($urandom_range(17, 22));
                default: op = 6'($urandom_range(23, 63));
            endcase
            issue(op, 1'($urandom), 4'($urandom));
        end

        for (int n = 0; n < 50 && q.size() > 0; n++) step();
        chk("scoreboard_drained", q.size(), 0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
